// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes and oversamples rxIn, recovers start/data/parity/stop framing
// and hands each word to the consumer over a valid/ready holding register.
module uart_rx_deserializer #(
  parameter int CLK_HZ       = 1_843_200,
  parameter int BAUD_RATE    = 9600,
  parameter int OVERSAMPLING = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxIn,
  input  logic [3:0]            cfgDataBits,
  input  logic                  cfgParityEn,
  input  logic                  cfgParityType,
  input  logic [1:0]            cfgStopBits,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxParityErr,
  output logic                  rxFrameErr,
  output logic                  rxValid,
  input  logic                  rxReady,
  output logic                  overrunErr,
  output logic [2:0]            dbgState
);
  // Handshake: a word transfers on every rising clk edge where rxValid && rxReady are both 1;
  // rxValid/rxData/status stay stable until that transfer, and rxReady may change freely.
  localparam int TICK_DIV = CLK_HZ / (BAUD_RATE * OVERSAMPLING);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLING);
  localparam logic [DW-1:0] DIV_M1  = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLING - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, sync3_q;
  logic [DW-1:0]         div_q, div_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]            nbits_q, nbits_d, nbits_cfg;
  logic                  par_en_q, par_en_d, par_type_q, par_type_d, two_stop_q, two_stop_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, pout_q, fout_q, ovr_q;
  logic                  start_edge, tick, sample_pt, last_data, last_stop;

  assign start_edge = (state_q == IDLE) && sync3_q && !sync2_q;
  assign tick       = (div_q == DIV_M1);
  assign sample_pt  = tick && (tick_cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1));
  assign last_data  = (bit_cnt_q == nbits_q - 4'd1);
  assign last_stop  = (stop_cnt_q == two_stop_q);
  assign nbits_cfg  = (cfgDataBits >= 4'd5 && cfgDataBits <= 4'd8) ? cfgDataBits : 4'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      state_q <= IDLE;
    end else begin
      sync1_q <= rxIn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = START;
      START:   if (sample_pt) state_d = sync2_q ? IDLE : DATA;
      DATA:    if (sample_pt && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (sample_pt) state_d = STOP;
      STOP:    if (sample_pt && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d      = tick ? '0 : div_q + DW'(1);
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    if (start_edge) begin
      // Frame config is captured once here so mid-frame changes cannot corrupt the word.
      div_d      = '0;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      shift_d    = '0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      nbits_d    = nbits_cfg;
      par_en_d   = cfgParityEn;
      par_type_d = cfgParityType;
      two_stop_d = (cfgStopBits == 2'd2);
    end else if (state_q != IDLE && tick) begin
      tick_cnt_d = sample_pt ? '0 : tick_cnt_q + TW'(1);
      if (sample_pt) begin
        case (state_q)
          DATA: begin
            shift_d   = shift_q | (DATA_WIDTH'(sync2_q) << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          PARITY: perr_d = (^shift_q) ^ sync2_q ^ par_type_q;
          STOP: begin
            if (!sync2_q) ferr_d = 1'b1;
            stop_cnt_d = 1'b1;
            done_d     = last_stop;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
    end
  end

  // Holding register: a completed word loads if the slot is empty or is being popped now.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      pout_q  <= 1'b0;
      fout_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q && (!valid_q || rxReady)) begin
        data_q  <= shift_q;
        pout_q  <= perr_q;
        fout_q  <= ferr_q;
        valid_q <= 1'b1;
      end else if (done_q) begin
        ovr_q <= 1'b1;
      end else if (valid_q && rxReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rxData      = data_q;
  assign rxParityErr = pout_q;
  assign rxFrameErr  = fout_q;
  assign rxValid     = valid_q;
  assign overrunErr  = ovr_q;
  assign dbgState    = state_q;
endmodule
